pll_reset_sequencer: RTL

//  Consumes the PLL output clock and its raw LOCK flag. Produces a clean, glitch-free system reset
//  (active-low) and a ready flag for the logic in the PLL clock domain.

---
 rtl/pll_reset_sequencer_pkg.sv | 43 ++++
 rtl/pll_reset_sequencer_sync2.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: sequencer state
// encoding and small elaboration-time helper functions.
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  // Number of bits needed to hold the values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (remaining > 0) begin
        result = result + 1;
        remaining = remaining >> 1;
      end
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

  // Largest of three integers, used to size the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end
    if (c > m) begin
      m = c;
    end
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchronizer for a single-bit level crossing into the clock
// domain. Both stages clear to 0 while resetn is low.
module pll_reset_sequencer_sync2 (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  // First stage may go metastable; the second stage gives it a full cycle to settle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: holds the system in reset until the PLL lock flag
// has been stable long enough, drops back into reset on lock loss, counts
// loss events and emits a periodic timebase tick while running.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int CLOCK_HZ      = 60_000_000,
  parameter int TICK_HZ       = 1_000_000,
  parameter int HOLD_CYCLES   = 16,
  parameter int STABLE_CYCLES = 6000,
  parameter int LOSS_W        = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              locked,
  output logic              sys_resetn,
  output logic              ready,
  output logic              tick,
  output logic [LOSS_W-1:0] loss_count
);

  localparam int DIV   = CLOCK_HZ / TICK_HZ;
  localparam int CNT_W = clog2(max3(HOLD_CYCLES, STABLE_CYCLES, DIV));

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(DIV - 1);

  // Reject parameter sets the counter and tick divider cannot honour.
  generate
    if ((CLOCK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
      $error("pll_reset_sequencer: CLOCK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (HOLD_CYCLES < 1 || STABLE_CYCLES < 1) begin : g_bad_cycles
      $error("pll_reset_sequencer: HOLD_CYCLES and STABLE_CYCLES must be >= 1");
    end
  endgenerate

  seq_state_t       state;
  seq_state_t       next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             locked_s;
  logic             loss_inc;
  logic             tick_c;

  pll_reset_sequencer_sync2 u_lock_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (locked),
    .q      (locked_s)
  );

  // State and shared counter registers; resetn forces a fresh HOLD entry.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= HOLD;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state, counter and tick decode; tick is gated by lock so it never fires as RUN is left.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    loss_inc   = 1'b0;
    tick_c     = 1'b0;
    case (state)
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          next_state = WAIT_LOCK;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        next_cnt = '0;
        if (locked_s) begin
          next_state = STABLE;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          next_cnt   = '0;
        end else if (cnt == STABLE_LAST) begin
          next_state = RUN;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          next_state = HOLD;
          next_cnt   = '0;
          loss_inc   = 1'b1;
        end else begin
          tick_c = (cnt == DIV_LAST);
          if (cnt == DIV_LAST) begin
            next_cnt = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end
      default: begin
        next_state = HOLD;
        next_cnt   = '0;
      end
    endcase
  end

  assign tick = tick_c;

  // Output flops look ahead at next_state so they are high exactly while in RUN.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sys_resetn <= 1'b0;
      ready      <= 1'b0;
    end else begin
      sys_resetn <= (next_state == RUN);
      ready      <= (next_state == RUN);
    end
  end

  // Lock-loss counter saturates at all-ones; reset clears it even on a coincident loss.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      loss_count <= '0;
    end else if (loss_inc && (loss_count != {LOSS_W{1'b1}})) begin
      loss_count <= loss_count + 1'b1;
    end
  end

endmodule
